sd_block_buffer: RTL
====================

# sd_block_buffer

Ping-pong block buffer directly downstream of the 4-bit SD data reader.
- Captures each received data block (byte stream with sop/eop) into one of two banks.
- Latches the reader's end-of-block status once the reader goes idle.
- Replays committed blocks, oldest first, on a valid/ready byte stream toward the host/DMA side.
- Lets the reader fill one bank while the host drains the other; flags overflow when both banks are occupied.

## Interface
Parameters:
- DEPTH, 512: bytes per bank; power of two, max 512.

Ports (reset rst_n, asynchronous, active-low; clock clk):
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_sd_run  in  1  reader busy; rising edge opens a block, falling edge closes it
- i_sd_result  in  8  reader status; bit0 timeout, bits4:1 CRC fail per data line
- i_st_data  in  8  received byte
- i_st_vld  in  1  byte valid; accepted every cycle it is high
- i_st_sop  in  1  first byte of block
- i_st_eop  in  1  last byte or abort marker
- o_st_rdy  out  1  high while the current block has a bank (informational; the reader does not stall)
- o_rd_data  out  8  replayed byte
- o_rd_vld  out  1  replay byte valid
- i_rd_rdy  in  1  replay consumer ready
- o_rd_sop  out  1  first replay byte of block
- o_rd_eop  out  1  last replay byte of block
- o_blk_len  out  10  length of head block, 0..DEPTH
- o_blk_status  out  8  i_sd_result captured for head block
- o_last_status  out  8  status of most recently closed block, including dropped/empty blocks
- o_overflow  out  1  sticky: a block arrived with no free bank
- i_clr_overflow  in  1  synchronous clear of o_overflow

## Operation
Write FSM:
- W_IDLE -> W_FILL on i_sd_run 0->1, if a bank is free. Claims the free bank (bank 0 preferred when both are free), sets write address and length to 0, o_st_rdy=1.
- If no bank is free, go to W_SKIP, set o_overflow, o_st_rdy=0.
- W_FILL: each cycle with i_st_vld, write i_st_data at the current address, then address+1.
  - i_st_sop with i_st_vld restarts the address at 0; that byte goes to address 0.
  - Bytes beyond DEPTH are discarded; length saturates at DEPTH.
- W_FILL -> W_IDLE on the first cycle with i_sd_run=0:
  - capture i_sd_result into the bank status and into o_last_status;
  - mark the bank full if length>0;
  - if length==0, free the bank immediately.
- W_SKIP -> W_IDLE when i_sd_run=0; only o_last_status updates.
- i_st_eop is used for checking only; closure is governed by i_sd_run.

Read side:
- Head pointer selects the oldest full bank; o_blk_len and o_blk_status reflect it while o_rd_vld is high.
- Bytes stream at addresses 0..len-1. A beat transfers when o_rd_vld & i_rd_rdy.
- o_rd_sop is high on address 0 and o_rd_eop on address len-1 (both high together when len==1).
- Transfer of the eop beat frees the bank; head advances to the other bank if it is full.
- Synchronous-read RAM with a one-entry prefetch register: full throughput while i_rd_rdy stays high.
- o_rd_data, o_rd_sop and o_rd_eop hold stable while o_rd_vld & ~i_rd_rdy.

Simultaneous events:
- A bank freed by the read side in the same cycle as i_sd_run rises is available to that block.
- A commit and a read release in the same cycle are both honoured.
- i_clr_overflow and a new overflow in the same cycle: set wins.

Reset: all outputs 0, both banks free, W_IDLE, head=bank 0. RAM contents are undefined. Reset mid-block drops the block.

## Timing
- Write: byte written the cycle after it is sampled; no backpressure.
- Commit: the bank is full one cycle after the i_sd_run falling edge is sampled.
- Replay: first o_rd_vld 2 cycles after the bank becomes full; thereafter 1 byte/cycle while i_rd_rdy=1.
- Bank free to re-claimable: 1 cycle after the eop beat transfers.

## Configuration
- SD_BUF_DROP_BAD_EN defined: blocks closing with i_sd_result!=0 are freed at commit and never replayed; o_last_status still records them.
- Undefined: every block with length>0 is replayed, with its status on o_blk_status.

## Test plan
- 512-byte block 0x00..0xFF repeating, result 0 -> replay 512 beats, sop on 0x00, eop on beat 511, o_blk_len=512, status 0x00.
- Two back-to-back 16-byte blocks with i_rd_rdy=0, then a third block -> o_overflow=1, third block absent from replay; the first two replay in order after i_rd_rdy=1.
- Reader timeout: i_sd_run high 30 cycles, no bytes, i_sd_result=0x01 -> no replay, o_last_status=0x01, bank free.
- 8-byte block, result 0x04: macro undefined -> replayed with o_blk_status=0x04; SD_BUF_DROP_BAD_EN defined -> no replay.
- 600 bytes into one block -> o_blk_len=512, bytes 0..511 replayed.
- Random i_rd_rdy toggling during a 64-byte replay -> no lost or duplicated bytes, data stable while stalled; rst_n pulse mid-fill -> all outputs 0, next block replays correctly.

Source files
------------

// File: rtl/sd_block_buffer.sv
// sd_block_buffer: two-bank capture/replay buffer behind the 4-bit SD data reader.
// Optional: define SD_BUF_DROP_BAD_EN to discard blocks that close with nonzero status.
module sd_block_buffer #(
  parameter int unsigned DEPTH = 512
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_sd_run,
  input  logic [7:0] i_sd_result,
  input  logic [7:0] i_st_data,
  input  logic       i_st_vld,
  input  logic       i_st_sop,
  input  logic       i_st_eop,
  output logic       o_st_rdy,
  output logic [7:0] o_rd_data,
  output logic       o_rd_vld,
  input  logic       i_rd_rdy,
  output logic       o_rd_sop,
  output logic       o_rd_eop,
  output logic [9:0] o_blk_len,
  output logic [7:0] o_blk_status,
  output logic [7:0] o_last_status,
  output logic       o_overflow,
  input  logic       i_clr_overflow
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [9:0]  DEPTH_L = 10'(DEPTH);

  typedef enum logic [1:0] {W_IDLE, W_FILL, W_SKIP} w_state_t;

  w_state_t        w_state;
  logic            run_q;
  logic            w_bank;
  logic [9:0]      w_addr;
  logic [1:0]      full;
  logic [1:0][9:0] bank_len;
  logic [1:0][7:0] bank_stat;
  logic            head;
  logic [9:0]      rd_addr;
  logic            ram_v;
  logic            ram_sop;
  logic            ram_eop;
  logic [7:0]      ram_q;
  logic [7:0]      mem [2*DEPTH];

  logic            run_rise;
  logic            rel;
  logic [1:0]      rel_vec;
  logic [1:0]      free_vec;
  logic [9:0]      w_addr_eff;
  logic            wr_en;
  logic            close;
  logic            keep;
  logic [1:0]      commit_vec;
  logic            out_load;
  logic            rd_issue;

  // A bank released by the eop beat this cycle counts as free for a block opening now.
  always_comb begin
    run_rise   = i_sd_run & ~run_q;
    rel        = o_rd_vld & i_rd_rdy & o_rd_eop;
    rel_vec    = head ? {rel, 1'b0} : {1'b0, rel};
    free_vec   = ~full | rel_vec;
    w_addr_eff = i_st_sop ? '0 : w_addr;
    wr_en      = (w_state == W_FILL) & i_sd_run & i_st_vld & (w_addr_eff < DEPTH_L);
    close      = (w_state == W_FILL) & ~i_sd_run;
`ifdef SD_BUF_DROP_BAD_EN
    keep       = close & (w_addr != '0) & (i_sd_result == '0);
`else
    keep       = close & (w_addr != '0);
`endif
    commit_vec = w_bank ? {keep, 1'b0} : {1'b0, keep};
    out_load   = ~o_rd_vld | i_rd_rdy;
    rd_issue   = full[head] & (rd_addr < bank_len[head]) & (~ram_v | out_load);
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[{w_bank, w_addr_eff[AW-1:0]}] <= i_st_data;
    if (rd_issue)
      ram_q <= mem[{head, rd_addr[AW-1:0]}];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state       <= W_IDLE;
      run_q         <= 1'b0;
      w_bank        <= 1'b0;
      w_addr        <= '0;
      o_st_rdy      <= 1'b0;
      o_overflow    <= 1'b0;
      o_last_status <= '0;
      bank_len      <= '0;
      bank_stat     <= '0;
    end else begin
      run_q <= i_sd_run;
      if (i_clr_overflow)
        o_overflow <= 1'b0;
      case (w_state)
        W_IDLE: begin
          if (run_rise) begin
            if (free_vec != 2'b00) begin
              w_bank   <= ~free_vec[0];
              w_addr   <= '0;
              o_st_rdy <= 1'b1;
              w_state  <= W_FILL;
            end else begin
              o_overflow <= 1'b1;
              o_st_rdy   <= 1'b0;
              w_state    <= W_SKIP;
            end
          end
        end
        W_FILL: begin
          if (!i_sd_run) begin
            o_st_rdy          <= 1'b0;
            o_last_status     <= i_sd_result;
            bank_stat[w_bank] <= i_sd_result;
            bank_len[w_bank]  <= w_addr;
            w_state           <= W_IDLE;
          end else if (wr_en) begin
            w_addr <= w_addr_eff + 10'd1;
          end
        end
        W_SKIP: begin
          if (!i_sd_run) begin
            o_last_status <= i_sd_result;
            w_state       <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read pipeline: issue -> RAM output (held while stalled) -> output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full      <= '0;
      head      <= 1'b0;
      rd_addr   <= '0;
      ram_v     <= 1'b0;
      ram_sop   <= 1'b0;
      ram_eop   <= 1'b0;
      o_rd_vld  <= 1'b0;
      o_rd_data <= '0;
      o_rd_sop  <= 1'b0;
      o_rd_eop  <= 1'b0;
    end else begin
      full <= (full & ~rel_vec) | commit_vec;
      if (!full[head] && full[~head])
        head <= ~head;
      if (rel)
        rd_addr <= '0;
      else if (rd_issue)
        rd_addr <= rd_addr + 10'd1;
      if (rd_issue) begin
        ram_v   <= 1'b1;
        ram_sop <= (rd_addr == '0);
        ram_eop <= (rd_addr == bank_len[head] - 10'd1);
      end else if (out_load) begin
        ram_v <= 1'b0;
      end
      if (out_load) begin
        o_rd_vld <= ram_v;
        if (ram_v) begin
          o_rd_data <= ram_q;
          o_rd_sop  <= ram_sop;
          o_rd_eop  <= ram_eop;
        end
      end
    end
  end

  assign o_blk_len    = o_rd_vld ? bank_len[head]  : '0;
  assign o_blk_status = o_rd_vld ? bank_stat[head] : '0;

  eop_inside_run: assert property (@(posedge clk) disable iff (!rst_n)
    (i_st_vld && i_st_eop) |-> i_sd_run);

endmodule
